clkgen_ctrl: RTL and testbench

Run/stop/step controller for the slow-clock divider. It owns the half-period counter and limit register, and produces clkout plus a one-cycle toggle tick in the clkin domain. Two command requesters share it through round-robin arbitration: port 0 is the switch/key panel and port 1 is the keyboard/host logic. It sits between the 50 MHz board clock and the counter/display blocks that consume slow clocks.

---
 rtl/clkgen_ctrl.sv | 118 +++++++++++
 tb/tb_clkgen_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clkgen_ctrl.sv
// Run/stop/step controller for the slow-clock divider with two round-robin command ports.
// CLKGEN_CTRL_AUTORUN_EN: when defined, reset leaves the divider in RUN instead of STOP.
module clkgen_ctrl #(
  parameter int CLK_IN_HZ = 50000000,
  parameter int DEF_FREQ  = 1000,
  parameter int DEF_LIMIT = CLK_IN_HZ / 2 / DEF_FREQ,
  parameter int CNT_W     = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [CNT_W-1:0] req0_data,
  output logic             gnt0,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [CNT_W-1:0] req1_data,
  output logic             gnt1,
  output logic             clkout,
  output logic             tick,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] limit
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_STOP = 2'd1,
    OP_STEP = 2'd2,
    OP_LOAD = 2'd3
  } op_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             rr_last;

  logic [CNT_W-1:0] lim_eff;
  logic [CNT_W:0]   cnt_inc;
  logic             wrap;
  logic             elig0, elig1;
  logic             acc0, acc1, acc;
  op_t              acc_op;
  logic [CNT_W-1:0] acc_data;

  assign state = st;

  always_comb begin
    lim_eff = (limit == '0) ? CNT_W'(1) : limit;
    cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    wrap    = (st != ST_STOP) && (cnt_inc >= {1'b0, lim_eff});
  end

  // A granted command is still on the bus during its gnt cycle, so mask it out.
  always_comb begin
    elig0    = req0_valid & ~gnt0;
    elig1    = req1_valid & ~gnt1;
    acc0     = 1'b0;
    acc1     = 1'b0;
    if (st != ST_STEP) begin
      acc0 = elig0 & (~elig1 | rr_last);
      acc1 = elig1 & (~elig0 | ~rr_last);
    end
    acc      = acc0 | acc1;
    acc_op   = acc1 ? op_t'(req1_op) : op_t'(req0_op);
    acc_data = acc1 ? req1_data : req0_data;
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
`ifdef CLKGEN_CTRL_AUTORUN_EN
      st      <= ST_RUN;
`else
      st      <= ST_STOP;
`endif
      cnt     <= '0;
      limit   <= CNT_W'(DEF_LIMIT);
      clkout  <= 1'b0;
      tick    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      gnt0 <= acc0;
      gnt1 <= acc1;
      tick <= wrap;
      if (acc) rr_last <= acc1;

      // Toggle decision is based on pre-command state and limit.
      if (wrap) begin
        clkout <= ~clkout;
        cnt    <= '0;
      end else if (st != ST_STOP) begin
        cnt <= cnt_inc[CNT_W-1:0];
      end

      if (wrap && st == ST_STEP) st <= ST_STOP;

      if (acc) begin
        case (acc_op)
          OP_RUN:  st <= ST_RUN;
          OP_STOP: st <= ST_STOP;
          OP_STEP: st <= ST_STEP;
          OP_LOAD: begin
            limit <= acc_data;
            cnt   <= '0;
          end
          default: st <= st;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Randomized two-port command stimulus against a countdown-based reference of the divider.
module tb_clkgen_ctrl;
  localparam int CNT_W = 32;
  localparam int DEFL  = 4;
  localparam int NCYC  = 4000;

  logic             clkin = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [1:0]       req0_op, req1_op;
  logic [CNT_W-1:0] req0_data, req1_data;
  logic             gnt0, gnt1, clkout, tick;
  logic [1:0]       state;
  logic [CNT_W-1:0] limit;

  always #5 clkin = ~clkin;

  clkgen_ctrl #(
    .CLK_IN_HZ(8000),
    .DEF_FREQ (1000),
    .CNT_W    (CNT_W)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_op   (req0_op),
    .req0_data (req0_data),
    .gnt0      (gnt0),
    .req1_valid(req1_valid),
    .req1_op   (req1_op),
    .req1_data (req1_data),
    .gnt1      (gnt1),
    .clkout    (clkout),
    .tick      (tick),
    .state     (state),
    .limit     (limit)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: tracks edges remaining until the next toggle rather than a count-up value.
  int          m_state;
  bit          m_clk, m_tick, m_g0, m_g1, m_rr;
  logic [31:0] m_limit;
  int unsigned m_rem;
  int          n_toggles;

  function automatic int unsigned lim_of(input logic [31:0] x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic model_reset();
`ifdef CLKGEN_CTRL_AUTORUN_EN
    m_state = 1;
`else
    m_state = 0;
`endif
    m_clk = 0; m_tick = 0; m_g0 = 0; m_g1 = 0; m_rr = 1;
    m_limit = DEFL;
    m_rem = DEFL;
  endtask

  task automatic model_step();
    bit e0, e1, a0, a1, tog;
    int ns;
    logic [1:0]  o;
    logic [31:0] d;
    if (rst) begin
      model_reset();
      return;
    end
    e0 = req0_valid && !m_g0;
    e1 = req1_valid && !m_g1;
    a0 = 0; a1 = 0;
    if (m_state != 2) begin
      if (e0 && e1) begin
        if (m_rr) a0 = 1; else a1 = 1;
      end else begin
        a0 = e0; a1 = e1;
      end
    end
    tog = (m_state != 0) && (m_rem == 1);
    if (tog) m_rem = lim_of(m_limit);
    else if (m_state != 0) m_rem = m_rem - 1;
    ns = (m_state == 2 && tog) ? 0 : m_state;
    if (a0 || a1) begin
      o = a1 ? req1_op : req0_op;
      d = a1 ? req1_data : req0_data;
      m_rr = a1;
      case (o)
        2'd0: ns = 1;
        2'd1: ns = 0;
        2'd2: ns = 2;
        default: begin
          m_limit = d;
          m_rem = lim_of(d);
        end
      endcase
    end
    m_state = ns;
    m_clk = m_clk ^ tog;
    m_tick = tog;
    m_g0 = a0;
    m_g1 = a1;
    if (tog) n_toggles++;
  endtask

  bit done0, done1;
  int rst_left;

  task automatic new_req(output logic v, output logic [1:0] op, output logic [CNT_W-1:0] d);
    v  = ($urandom_range(0, 2) == 0);
    op = 2'($urandom_range(0, 3));
    d  = CNT_W'($urandom_range(0, 6));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_data = 0;
    req1_valid = 0; req1_op = 0; req1_data = 0;
    done0 = 0; done1 = 0; rst_left = 0; n_toggles = 0;
    repeat (2) @(posedge clkin);
    #1;
    rst = 1'b0;
    model_reset();

    chk("rst_clkout", 32'(clkout), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_limit", limit, 32'(DEFL));
`ifdef CLKGEN_CTRL_AUTORUN_EN
    chk("rst_state", 32'(state), 32'd1);
`else
    chk("rst_state", 32'(state), 32'd0);
`endif

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      chk("clkout", 32'(clkout), 32'(m_clk));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("state", 32'(state), 32'(m_state));
      chk("limit", limit, m_limit);
      chk("gnt0", 32'(gnt0), 32'(m_g0));
      chk("gnt1", 32'(gnt1), 32'(m_g1));

      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        rst = 1'b0;
      end

      if (rst) begin
        req0_valid = 0; req1_valid = 0; done0 = 0; done1 = 0;
      end else begin
        // Hold through the gnt cycle; afterwards drop or present the next command.
        if (m_g0) done0 = 1;
        else if (done0 || !req0_valid) begin
          done0 = 0;
          new_req(req0_valid, req0_op, req0_data);
        end
        if (m_g1) done1 = 1;
        else if (done1 || !req1_valid) begin
          done1 = 0;
          new_req(req1_valid, req1_op, req1_data);
        end
      end

      model_step();
      @(posedge clkin);
      #1;
    end

    chk("toggles_seen", 32'(n_toggles > 10), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
